// File: rtl/run_det_pkg.sv
// Shared constants for the run-length detector: FSM state encoding and report modes.
package run_det_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_HIT   = 2'd2;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. clr zeroes the count and beats inc; load0 restarts
// the count from zero, taking this cycle's inc into account.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    input  logic         load0,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] Q_MAX = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load0) begin
            q <= W'(inc);
        end else if (inc && (q != Q_MAX)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/run_length_detector.sv
// Serial run-length detector: flags runs of cfg_polarity reaching a programmable
// threshold, reports each qualifying run's final length and counts detections.
module run_length_detector
    import run_det_pkg::*;
#(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic             din,
    input  logic             cfg_polarity,
    input  logic [LEN_W-1:0] cfg_threshold,
    input  logic             cfg_mode,
    input  logic             clr_count,
    output logic             detected,
    output logic [LEN_W-1:0] run_len,
    output logic             run_done,
    output logic [LEN_W-1:0] run_done_len,
    output logic [CNT_W-1:0] event_count
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [LEN_W-1:0] thr;
    logic [LEN_W-1:0] len_inc;
    logic             match;
    logic             reach;
    logic             det_nxt;
    logic             done_nxt;
    logic             run_inc;
    logic             run_restart;

    // A zero threshold behaves as one; the incremented length saturates.
    assign thr         = (cfg_threshold == '0) ? LEN_W'(1) : cfg_threshold;
    assign len_inc     = (run_len == LEN_MAX) ? run_len : run_len + LEN_W'(1);
    assign match       = (din == cfg_polarity);
    assign reach       = (len_inc >= thr);
    assign run_inc     = din_valid && match;
    assign run_restart = din_valid && !match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        det_nxt   = 1'b0;
        done_nxt  = 1'b0;
        if (din_valid) begin
            if (match) begin
                state_nxt = reach ? ST_HIT : ST_COUNT;
                det_nxt   = reach && ((cfg_mode == MODE_CONT) || (state != ST_HIT));
            end else begin
                state_nxt = ST_IDLE;
                done_nxt  = (state == ST_HIT);
            end
        end
    end

    // Output pulses and the captured length of the run that just ended.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            detected     <= 1'b0;
            run_done     <= 1'b0;
            run_done_len <= '0;
        end else begin
            detected <= det_nxt;
            run_done <= done_nxt;
            if (done_nxt) begin
                run_done_len <= run_len;
            end
        end
    end

    sat_counter #(.W(LEN_W)) u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (run_inc),
        .clr   (1'b0),
        .load0 (run_restart),
        .q     (run_len)
    );

    sat_counter #(.W(CNT_W)) u_evt_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (det_nxt),
        .clr   (clr_count),
        .load0 (1'b0),
        .q     (event_count)
    );

endmodule

// File: doc/run_length_detector.md
# run_length_detector

Parametrised serial run-length detector for the FSM block library. It watches a qualified bit stream and flags runs of a programmable polarity that reach a programmable threshold. It supports continuous or one-shot reporting, reports each qualifying run's final length, and keeps a saturating event counter. It is the general-purpose successor to the fixed three-ones detector, and sits directly behind any serial receiver or line monitor.

## Interface
- `LEN_W`, 8: width of the threshold, the run counter and the reported run length.
- `CNT_W`, 16: width of the event counter.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `din_valid`  in  1  qualifies `din`; samples with `din_valid=0` are ignored.
- `din`  in  1  serial data bit.
- `cfg_polarity`  in  1  bit value that forms a run (1 = runs of ones, 0 = runs of zeros).
- `cfg_threshold`  in  `LEN_W`  minimum run length to detect; 0 is treated as 1.
- `cfg_mode`  in  1  0 = continuous (pulse on every matching sample at or beyond threshold); 1 = one-shot (pulse once per run).
- `clr_count`  in  1  synchronous clear of `event_count`.
- `detected`  out  1  registered detection pulse.
- `run_len`  out  `LEN_W`  current run length, saturating.
- `run_done`  out  1  one-cycle pulse when a qualifying run ends.
- `run_done_len`  out  `LEN_W`  final length of the run just ended; holds its value until the next `run_done`.
- `event_count`  out  `CNT_W`  number of `detected` pulses, saturating.

## Operation
States:
- IDLE: `run_len=0`.
- COUNT: `0 < run_len < thr`.
- HIT: `run_len >= thr`.
- Here `thr = max(cfg_threshold, 1)`.

Transitions happen only on cycles with `din_valid=1`. A sample matches when `din == cfg_polarity`.
- **Matching sample:**
  - `run_len <= sat(run_len+1)`.
  - Go to HIT if the new length is `>= thr`, otherwise COUNT.
- **Non-matching sample:**
  - `run_len <= 0`, go to IDLE.
  - If the old state was HIT: pulse `run_done` and set `run_done_len <= run_len` (old value).

Detection, evaluated on a matching sample that leaves the block in HIT:
- Mode 0: `detected=1`.
- Mode 1: `detected=1` only if the old state was not HIT.

Other rules:
- `detected` and `run_done` are 0 on every cycle without a valid sample.
- `run_len` saturates at `2^LEN_W-1`. The state stays HIT while saturated, and `run_done_len` reports the saturated value.
- `event_count` increments when `detected` is set and saturates at `2^CNT_W-1`. If `clr_count` coincides with an increment, clear wins and the result is 0.
- Config inputs are sampled on every valid cycle. A threshold change mid-run is compared against the current `run_len` at the next valid sample. Lowering the threshold below `run_len` moves the block to HIT on the next matching sample, and one-shot mode then pulses once.
- In state HIT with `thr` raised above `run_len`: the next matching sample re-evaluates and may move the block to COUNT, with no `run_done`.

## Timing
- All outputs are registered. `detected`, `run_done`, `run_done_len`, `run_len` and `event_count` update on the clock edge that samples the qualifying `din`, so latency from `din` to output is 1 cycle.
- `event_count` reflects a detection in the same cycle that `detected` is high.
- Reset (asynchronous, at any time, including mid-run) sets:
  - state to IDLE;
  - `run_len`, `run_done_len` and `event_count` to 0;
  - `detected` and `run_done` to 0.
- No partial run is reported after reset.
- Back-to-back valid samples are supported at full rate. Gaps in `din_valid` do not break a run.

## Structure
- Package `run_det_pkg`:
  - state encoding: IDLE, COUNT, HIT as 2-bit constants;
  - mode constants `MODE_CONT=0`, `MODE_ONESHOT=1`.
- Sub-module `sat_counter` (parameter `W`; inputs `inc`, `clr`, `load0`; output `q`, saturating). It is instantiated for `run_len` and for `event_count`.
- The top level holds the FSM, threshold normalisation and the `run_done` capture.

## Test plan
- Polarity 1, threshold 3, mode 0, stream 1,1,1,1,0 all valid → `detected` high on the 3rd and 4th samples (+1 cycle), `run_done=1` with `run_done_len=4` after the 0, `event_count=2`.
- Same stream, mode 1 → a single `detected` on the 3rd sample, `run_done_len=4`, `event_count=1`.
- Polarity 0, threshold 0 (treated as 1), stream 0,1,0 → `detected` on both 0s, each followed by `run_done` with length 1 on the next non-matching sample where applicable.
- `LEN_W=2`, threshold 2, six consecutive 1s → `run_len` sticks at 3, detections continue (mode 0), terminating 0 gives `run_done_len=3`.
- Run of 1,1 interleaved with `din_valid=0` gaps, then 1 → detection on the third valid 1. Assert `reset` mid-run (after two 1s): all outputs 0 and no `run_done`, and a new run needs 3 fresh 1s.
- `event_count` preset near saturation (`CNT_W=2`, five detections) → holds at 3. `clr_count` asserted on a detect cycle → 0.
